// File: rtl/thunderbird_tail_lights.sv
// Thunderbird tail-light turn-signal sequencer stepped by a divided Tick enable.
// Optional brake overlay is enabled by defining TBIRD_BRAKE_EN.
module thunderbird_tail_lights #(
    parameter int HOLD_TICKS = 1
) (
    input  logic Clk_In,
    input  logic Rst_N,
    input  logic Tick,
    input  logic Left,
    input  logic Right,
    input  logic Haz,
`ifdef TBIRD_BRAKE_EN
    input  logic Brake,
`endif
    output logic LA,
    output logic LB,
    output logic LC,
    output logic RA,
    output logic RB,
    output logic RC
);

    // state | meaning
    // IDLE  | all lamps off, waiting for a request
    // L1-L3 | left sweep, inner lamp first
    // R1-R3 | right sweep, inner lamp first
    // LR3   | hazard / both sides, all six lamps on
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        LR3  = 3'd7
    } state_t;

    localparam logic [3:0] STEP_TC = 4'(HOLD_TICKS - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] tick_cnt;
    logic [5:0] lamps_q;
    logic       step;
    logic       brake_s;

`ifdef TBIRD_BRAKE_EN
    assign brake_s = Brake;
`else
    assign brake_s = 1'b0;
`endif

    assign step = Tick && (tick_cnt == STEP_TC);

    always_comb begin
        state_next = state;
        if (step) begin
            case (state)
                IDLE: begin
                    if (Haz || (Left && Right)) state_next = LR3;
                    else if (Left)              state_next = L1;
                    else if (Right)             state_next = R1;
                    else                        state_next = IDLE;
                end
                L1:      state_next = Haz ? LR3 : L2;
                L2:      state_next = Haz ? LR3 : L3;
                L3:      state_next = Haz ? LR3 : IDLE;
                R1:      state_next = Haz ? LR3 : R2;
                R2:      state_next = Haz ? LR3 : R3;
                R3:      state_next = Haz ? LR3 : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Returns {RC, RB, RA, LC, LB, LA}; brake lights whichever side is not sweeping.
    function automatic logic [5:0] decode(input state_t s, input logic brk);
        logic [2:0] l;
        logic [2:0] r;
        l = 3'b000;
        r = 3'b000;
        case (s)
            L1:      l = 3'b001;
            L2:      l = 3'b011;
            L3:      l = 3'b111;
            R1:      r = 3'b001;
            R2:      r = 3'b011;
            R3:      r = 3'b111;
            LR3: begin
                l = 3'b111;
                r = 3'b111;
            end
            default: begin
                l = 3'b000;
                r = 3'b000;
            end
        endcase
        if (brk) begin
            if (!(s == L1 || s == L2 || s == L3)) l = 3'b111;
            if (!(s == R1 || s == R2 || s == R3)) r = 3'b111;
        end
        return {r, l};
    endfunction

    always_ff @(posedge Clk_In) begin
        if (!Rst_N) begin
            state    <= IDLE;
            tick_cnt <= 4'd0;
            lamps_q  <= 6'd0;
        end else begin
            state <= state_next;
            if (step)
                tick_cnt <= 4'd0;
            else if (Tick)
                tick_cnt <= tick_cnt + 4'd1;
`ifdef TBIRD_BRAKE_EN
            lamps_q <= decode(state_next, brake_s);
`else
            if (step)
                lamps_q <= decode(state_next, brake_s);
`endif
        end
    end

    assign {RC, RB, RA, LC, LB, LA} = lamps_q;

endmodule

// File: tb/tb_thunderbird_tail_lights.sv
// Directed self-checking bench for thunderbird_tail_lights (HOLD_TICKS=1 and =3 instances).
module tb_thunderbird_tail_lights;

    logic Clk_In = 1'b0;
    logic Rst_N  = 1'b0;
    logic Tick   = 1'b0;
    logic Left   = 1'b0;
    logic Right  = 1'b0;
    logic Haz    = 1'b0;
`ifdef TBIRD_BRAKE_EN
    logic Brake  = 1'b0;
`endif

    logic la1, lb1, lc1, ra1, rb1, rc1;
    logic la3, lb3, lc3, ra3, rb3, rc3;

    int checks = 0;
    int errors = 0;

    always #10 Clk_In = ~Clk_In;

    thunderbird_tail_lights #(.HOLD_TICKS(1)) u_h1 (
        .Clk_In(Clk_In), .Rst_N(Rst_N), .Tick(Tick),
        .Left(Left), .Right(Right), .Haz(Haz),
`ifdef TBIRD_BRAKE_EN
        .Brake(Brake),
`endif
        .LA(la1), .LB(lb1), .LC(lc1), .RA(ra1), .RB(rb1), .RC(rc1)
    );

    thunderbird_tail_lights #(.HOLD_TICKS(3)) u_h3 (
        .Clk_In(Clk_In), .Rst_N(Rst_N), .Tick(Tick),
        .Left(Left), .Right(Right), .Haz(Haz),
`ifdef TBIRD_BRAKE_EN
        .Brake(Brake),
`endif
        .LA(la3), .LB(lb3), .LC(lc3), .RA(ra3), .RB(rb3), .RC(rc3)
    );

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check both sides of the HOLD_TICKS=1 instance; patterns are {C,B,A}.
    task automatic check1(input string tag, input logic [2:0] l_exp, input logic [2:0] r_exp);
        check({tag, ".left"},  {lc1, lb1, la1}, l_exp);
        check({tag, ".right"}, {rc1, rb1, ra1}, r_exp);
    endtask

    task automatic check3(input string tag, input logic [2:0] l_exp, input logic [2:0] r_exp);
        check({tag, ".left"},  {lc3, lb3, la3}, l_exp);
        check({tag, ".right"}, {rc3, rb3, ra3}, r_exp);
    endtask

    // One clock cycle with Tick high; returns 1 ns after the sampling edge.
    task automatic do_tick();
        Tick = 1'b1;
        @(posedge Clk_In);
        #1;
        Tick = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk_In);
            #1;
        end
    endtask

    task automatic apply_reset();
        Rst_N = 1'b0;
        idle_cycles(2);
        Rst_N = 1'b1;
    endtask

    initial begin
        // Reset held with Left and Tick active: lamps stay dark
        @(posedge Clk_In);
        #1;
        Rst_N = 1'b0;
        Left  = 1'b1;
        Tick  = 1'b1;
        idle_cycles(2);
        check1("reset_h1", 3'b000, 3'b000);
        check3("reset_h3", 3'b000, 3'b000);
        Rst_N = 1'b1;
        Tick  = 1'b0;
        idle_cycles(1);
        check1("post_reset_quiet", 3'b000, 3'b000);

        // Left held for four ticks
        do_tick(); check1("left_t1", 3'b001, 3'b000);
        idle_cycles(3); check1("left_hold_between", 3'b001, 3'b000);
        do_tick(); check1("left_t2", 3'b011, 3'b000);
        do_tick(); check1("left_t3", 3'b111, 3'b000);
        do_tick(); check1("left_t4", 3'b000, 3'b000);

        // Dropping Left mid-sequence does not abort it
        do_tick(); check1("drop_l1", 3'b001, 3'b000);
        Left = 1'b0;
        do_tick(); check1("drop_l2", 3'b011, 3'b000);
        do_tick(); check1("drop_l3", 3'b111, 3'b000);
        do_tick(); check1("drop_idle", 3'b000, 3'b000);
        do_tick(); check1("stay_idle", 3'b000, 3'b000);

        // Hazard raised during a right sequence
        Right = 1'b1;
        do_tick(); check1("haz_r1", 3'b000, 3'b001);
        Haz = 1'b1;
        do_tick(); check1("haz_on1", 3'b111, 3'b111);
        do_tick(); check1("haz_off1", 3'b000, 3'b000);
        do_tick(); check1("haz_on2", 3'b111, 3'b111);
        do_tick(); check1("haz_off2", 3'b000, 3'b000);
        Haz   = 1'b0;
        Right = 1'b0;

        // Both sides from IDLE
        Left  = 1'b1;
        Right = 1'b1;
        do_tick(); check1("both_on", 3'b111, 3'b111);
        Left  = 1'b0;
        Right = 1'b0;
        do_tick(); check1("both_off", 3'b000, 3'b000);

        // Tick held high for three cycles counts as three steps
        Right = 1'b1;
        Tick  = 1'b1;
        @(posedge Clk_In); #1; check1("held_tick_r1", 3'b000, 3'b001);
        Right = 1'b0;
        @(posedge Clk_In); #1; check1("held_tick_r2", 3'b000, 3'b011);
        @(posedge Clk_In); #1; check1("held_tick_r3", 3'b000, 3'b111);
        Tick = 1'b0;
        do_tick(); check1("held_tick_idle", 3'b000, 3'b000);

        // Reset mid-sequence wins over a coincident Tick
        Left = 1'b1;
        do_tick(); check1("midrst_l1", 3'b001, 3'b000);
        Rst_N = 1'b0;
        do_tick(); check1("midrst_cleared", 3'b000, 3'b000);
        Rst_N = 1'b1;
        do_tick(); check1("midrst_restart", 3'b001, 3'b000);

        // HOLD_TICKS=3: one step per three ticks, counter untouched by input changes
        Left = 1'b0;
        apply_reset();
        Left = 1'b1;
        do_tick(); check3("h3_t1", 3'b000, 3'b000);
        do_tick(); check3("h3_t2", 3'b000, 3'b000);
        do_tick(); check3("h3_t3", 3'b001, 3'b000);
        do_tick(); check3("h3_t4", 3'b001, 3'b000);
        do_tick(); check3("h3_t5", 3'b001, 3'b000);
        do_tick(); check3("h3_t6", 3'b011, 3'b000);
        Left = 1'b0;
        do_tick(); check3("h3_t7", 3'b011, 3'b000);
        do_tick(); check3("h3_t8", 3'b011, 3'b000);
        do_tick(); check3("h3_t9", 3'b111, 3'b000);

`ifdef TBIRD_BRAKE_EN
        apply_reset();
        Brake = 1'b1;
        idle_cycles(1); check1("brake_idle_on", 3'b111, 3'b111);
        Brake = 1'b0;
        idle_cycles(1); check1("brake_idle_off", 3'b000, 3'b000);
        Left = 1'b1;
        do_tick();
        do_tick(); check1("brake_l2_pre", 3'b011, 3'b000);
        Brake = 1'b1;
        idle_cycles(1); check1("brake_l2", 3'b011, 3'b111);
        Brake = 1'b0;
        Left  = 1'b0;
        idle_cycles(1); check1("brake_l2_release", 3'b011, 3'b000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
